// File: rtl/mux4_arbiter_if.sv
// Bundle of request, data and grant signals shared between the four
// requesters (master side) and the round-robin mux arbiter (slave side).
interface mux4_arbiter_if;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       data_out;
    logic       data_valid;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output data_in,
        input  grant,
        input  sel,
        input  data_out,
        input  data_valid,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  data_in,
        output grant,
        output sel,
        output data_out,
        output data_valid,
        output busy,
        output timeout
    );
endinterface

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter and sequencer for the shared 4:1 mux path.
// One requester is granted at a time, each grant is bounded to MAX_HOLD
// cycles, and every grant is followed by exactly one GAP cycle in which
// the next winner is chosen. The previous winner always has the lowest
// priority, so a force-released requester waits behind the others.
module mux4_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic           clk,
    input logic           rst_n,
    mux4_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // hold_cnt value at which the current grant has lasted MAX_HOLD cycles
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] last;
    logic [1:0] last_nx;
    logic [1:0] sel_q;
    logic [1:0] sel_nx;
    logic [7:0] hold_cnt;
    logic [7:0] hold_nx;
    logic       data_q;
    logic       data_nx;
    logic       valid_q;
    logic       valid_nx;
    logic       timeout_q;
    logic       timeout_nx;

    logic       win_vld;
    logic [1:0] win;
    logic [1:0] cand;

    // Round-robin pick: scan last+1, last+2, last+3, last (mod 4).
    always_comb begin
        win_vld = 1'b0;
        win     = last;
        cand    = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    // Next-state and next-register values for the IDLE/GRANT/GAP sequencer.
    always_comb begin
        state_nx   = state;
        last_nx    = last;
        sel_nx     = sel_q;
        hold_nx    = hold_cnt;
        data_nx    = data_q;
        valid_nx   = 1'b0;
        timeout_nx = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (win_vld) begin
                    state_nx = GRANT;
                    last_nx  = win;
                    sel_nx   = win;
                    hold_nx  = 8'd0;
                end else begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                data_nx  = bus.data_in[last];
                valid_nx = 1'b1;
                hold_nx  = hold_cnt + 8'd1;
                // A voluntary release wins over the hold limit.
                if (!bus.req[last]) begin
                    state_nx = GAP;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx   = GAP;
                    timeout_nx = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 2'd3;
            sel_q     <= 2'd0;
            hold_cnt  <= 8'd0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            sel_q     <= sel_nx;
            hold_cnt  <= hold_nx;
            data_q    <= data_nx;
            valid_q   <= valid_nx;
            timeout_q <= timeout_nx;
        end
    end

    // Grant and busy decode directly from state so reset drops them at once.
    always_comb begin
        bus.grant      = (state == GRANT) ? (4'b0001 << last) : 4'b0000;
        bus.busy       = (state != IDLE);
        bus.sel        = sel_q;
        bus.data_out   = data_q;
        bus.data_valid = valid_q;
        bus.timeout    = timeout_q;
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: a cycle model of the arbitration rules is checked
// against the DUT every cycle, and directed scenarios pin known values.
module tb_mux4_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mux4_arbiter_if bus();

    mux4_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: who owns the mux, for how long, and the round-robin pointer
    bit         m_owning = 1'b0;
    bit         m_gap    = 1'b0;
    int         m_owner  = 0;
    int         m_held   = 0;
    int         m_last   = 3;
    logic [1:0] m_sel    = 2'd0;
    logic       m_dout   = 1'b0;
    logic       m_dv     = 1'b0;
    logic       m_to     = 1'b0;

    function automatic int pick(input logic [3:0] r, input int after);
        for (int k = 1; k <= 4; k++) begin
            if (r[(after + k) % 4]) return (after + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model advanced on each clock edge or asynchronous reset.
    always begin
        int w;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_owning = 1'b0; m_gap = 1'b0; m_owner = 0; m_held = 0; m_last = 3;
            m_sel = 2'd0; m_dout = 1'b0; m_dv = 1'b0; m_to = 1'b0;
        end else if (m_owning) begin
            m_dout = bus.data_in[m_owner];
            m_dv   = 1'b1;
            m_held = m_held + 1;
            m_to   = 1'b0;
            if (!bus.req[m_owner]) begin
                m_owning = 1'b0; m_gap = 1'b1;
            end else if (m_held == MAX_HOLD) begin
                m_owning = 1'b0; m_gap = 1'b1; m_to = 1'b1;
            end
        end else begin
            m_dv  = 1'b0;
            m_to  = 1'b0;
            m_gap = 1'b0;
            w = pick(bus.req, m_last);
            if (w >= 0) begin
                m_owning = 1'b1; m_owner = w; m_last = w; m_held = 0;
                m_sel = 2'(w);
            end
        end
    end

    // Compare every cycle on the inactive edge.
    always @(negedge clk) begin
        check("grant",      8'(bus.grant),      m_owning ? 8'(4'b0001 << m_owner) : 8'd0);
        check("sel",        8'(bus.sel),        8'(m_sel));
        check("data_out",   8'(bus.data_out),   8'(m_dout));
        check("data_valid", 8'(bus.data_valid), 8'(m_dv));
        check("busy",       8'(bus.busy),       8'(m_owning | m_gap));
        check("timeout",    8'(bus.timeout),    8'(m_to));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req     = 4'($urandom);
        bus.data_in = 4'($urandom);

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.req     = 4'($urandom);
            bus.data_in = 4'($urandom);
        end
        check("rst_grant", 8'(bus.grant), 8'h0);
        check("rst_sel",   8'(bus.sel),   8'h0);
        check("rst_dv",    8'(bus.data_valid), 8'h0);
        check("rst_busy",  8'(bus.busy),  8'h0);
        check("rst_dout",  8'(bus.data_out), 8'h0);
        bus.req = 4'b0001; bus.data_in = 4'b0001; rst_n = 1'b1;
        cyc();
        check("first_grant", 8'(bus.grant), 8'h01);
        bus.req = 4'b0000;
        cyc();
        cyc();

        // Single requester held 3 cycles
        bus.req = 4'b0100; bus.data_in = 4'b0100;
        cyc();
        check("single_grant", 8'(bus.grant), 8'h04);
        check("single_sel",   8'(bus.sel),   8'h02);
        check("single_dv0",   8'(bus.data_valid), 8'h0);
        cyc();
        check("single_dout",  8'(bus.data_out),   8'h1);
        check("single_dv1",   8'(bus.data_valid), 8'h1);
        cyc();
        check("single_grant3", 8'(bus.grant), 8'h04);
        bus.req = 4'b0000;
        cyc();
        check("single_gap_grant", 8'(bus.grant), 8'h0);
        check("single_gap_busy",  8'(bus.busy),  8'h1);
        check("single_gap_dv",    8'(bus.data_valid), 8'h1);
        cyc();
        check("single_idle_busy", 8'(bus.busy), 8'h0);
        check("single_idle_dv",   8'(bus.data_valid), 8'h0);
        check("single_idle_sel",  8'(bus.sel), 8'h02);

        // Timeout: requester 1 held permanently, requester 3 joins at cycle 2
        bus.req = 4'b0010;
        cyc();
        for (int j = 0; j < 8; j++) begin
            check("to_grant", 8'(bus.grant), 8'h02);
            check("to_pulse_low", 8'(bus.timeout), 8'h0);
            if (j == 1) bus.req = 4'b1010;
            bus.data_in = 4'($urandom);
            cyc();
        end
        check("to_gap_grant", 8'(bus.grant),   8'h0);
        check("to_pulse",     8'(bus.timeout), 8'h1);
        cyc();
        check("to_next_grant", 8'(bus.grant),   8'h08);
        check("to_pulse_end",  8'(bus.timeout), 8'h0);
        bus.req = 4'b0010;
        cyc();
        check("to_gap2_grant", 8'(bus.grant), 8'h0);
        cyc();
        check("to_back_grant", 8'(bus.grant), 8'h02);

        // Drop coinciding with the hold limit
        for (int j = 0; j < 7; j++) begin
            bus.data_in = 4'($urandom);
            cyc();
        end
        check("drop_still_grant", 8'(bus.grant), 8'h02);
        bus.req = 4'b0000;
        cyc();
        check("drop_gap_grant", 8'(bus.grant),   8'h0);
        check("drop_gap_busy",  8'(bus.busy),    8'h1);
        check("drop_no_to",     8'(bus.timeout), 8'h0);
        cyc();

        // Asynchronous reset in the middle of a grant
        bus.req = 4'b0100; bus.data_in = 4'b0100;
        cyc();
        check("ar_grant", 8'(bus.grant), 8'h04);
        cyc();
        check("ar_dv_pre", 8'(bus.data_valid), 8'h1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_grant0", 8'(bus.grant),      8'h0);
        check("ar_dv0",    8'(bus.data_valid), 8'h0);
        check("ar_sel0",   8'(bus.sel),        8'h0);
        check("ar_to0",    8'(bus.timeout),    8'h0);
        cyc();
        rst_n = 1'b1; bus.req = 4'b1111;
        cyc();

        // Rotation: each winner releases after one cycle, then re-requests
        for (int i = 0; i < 5; i++) begin
            check("rot_grant", 8'(bus.grant), 8'(4'b0001 << (i % 4)));
            if (i < 4) begin
                bus.req     = 4'hF & ~(4'b0001 << (i % 4));
                bus.data_in = 4'($urandom);
                cyc();
                check("rot_gap", 8'(bus.grant), 8'h0);
                bus.req = 4'hF;
                cyc();
            end
        end
        bus.req = 4'b0000;
        cyc();
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_arbiter.md
# mux4_arbiter

Round-robin arbiter and sequencer for the shared 4:1 multiplexer path in the ULA datapath. Four requesters compete for the single mux output. The block grants one requester at a time, drives the mux 2-bit selector, and registers the selected data bit. It bounds each grant to MAX_HOLD cycles so that no requester can starve the others.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles a single grant may last; legal range 1..255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  4  level request, one bit per requester (bit i = requester i).
- data_in  input  4  data bit from each requester; bit i maps to mux input A/B/C/D for i=0/1/2/3.
- grant  output  4  one-hot grant; all-zero when no grant is active.
- sel  output  2  mux selector driven to the granted index; holds its last value when idle.
- data_out  output  1  registered copy of data_in[sel] from the previous GRANT cycle.
- data_valid  output  1  high when data_out was captured during a GRANT cycle.
- busy  output  1  high in GRANT and GAP states.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

## Operation
- Registered state:
  - state in {IDLE, GRANT, GAP}.
  - last winner pointer `last`, 2 bits.
  - hold counter `hold_cnt`, 8 bits.
- Arbitration is evaluated in IDLE and GAP.
  - Candidate priority order: last+1, last+2, last+3, last, all mod 4.
  - The first index with req=1 wins.
  - The previous winner therefore has the lowest priority.
- IDLE:
  - grant=0000, busy=0.
  - If req≠0: go to GRANT with winner w; set grant[w]=1, sel=w, last=w, hold_cnt=0.
  - If req=0: stay in IDLE.
- GRANT (winner w):
  - Each cycle: data_out←data_in[w], data_valid←1, hold_cnt←hold_cnt+1.
  - If req[w]=0: go to GAP with no timeout pulse.
  - Else if hold_cnt=MAX_HOLD-1: go to GAP and pulse timeout=1 for one cycle.
  - Else: stay in GRANT.
  - If req[w] drops in the same cycle that MAX_HOLD is reached, the drop takes precedence and timeout stays 0.
- GAP:
  - Always exactly one cycle, with grant=0000 and busy=1.
  - data_valid←0 at the end of the GAP cycle.
  - Arbitration as in IDLE: go to GRANT if req≠0, else IDLE.
  - A force-released requester that still requests is re-granted only after all other pending requesters.
- Outside GRANT, data_out holds its value and data_valid←0.
- Changes to req bits other than req[w] have no effect during GRANT.
- The following are never possible:
  - grant with more than one bit set;
  - two consecutive grants without a GAP cycle;
  - sel changing while grant≠0.

## Timing
- Reset (rst_n=0, effective immediately and asynchronously):
  - grant=0000, sel=00, data_out=0, data_valid=0, busy=0, timeout=0.
  - state=IDLE, last=3 (so requester 0 has first priority), hold_cnt=0.
- Reset asserted mid-grant drops grant in the same cycle, with no GAP and no timeout.
- Request-to-grant latency:
  - 1 edge: req sampled at edge k in IDLE → grant high after edge k.
  - From GAP: the next grant is visible 1 cycle after the previous grant drops.
- Data latency: data_out/data_valid lag grant by one cycle; the first valid data appears after the first edge in GRANT.
- Grant length:
  - Maximum MAX_HOLD cycles.
  - Minimum 1 cycle: req[w] already low at the first GRANT edge.
- Release latency: req[w] sampled low at edge k → grant=0000 after edge k.
- Throughput under continuous contention, with each requester releasing after n cycles: one grant every n+1 cycles.
- MAX_HOLD=1: every grant lasts exactly one cycle; timeout pulses whenever req[w] is still high at that edge.

## Test plan
- Reset:
  - Stimulus: rst_n low with random req/data_in.
  - Response: all outputs 0 and sel=00.
  - After release with req=0001, grant=0001 after the first edge.
- Single requester:
  - Stimulus: req=0100 held 3 cycles, data_in=0100.
  - Response:
    - grant=0100 and sel=10 for 3 cycles;
    - data_out=1 with data_valid=1 one cycle behind grant;
    - one GAP cycle, then IDLE.
- Rotation:
  - Stimulus: req=1111, each requester drops its req one cycle after being granted.
  - Response: grant sequence 0001, gap, 0010, gap, 0100, gap, 1000, gap, 0001.
- Timeout:
  - Stimulus: MAX_HOLD=8, req=0010 held permanently, req[3] raised at cycle 2.
  - Response:
    - grant=0010 for exactly 8 cycles;
    - timeout pulse in the following GAP cycle;
    - then grant=1000, then back to 0010.
- Simultaneous drop and limit:
  - Stimulus: req[w] dropped exactly at cycle MAX_HOLD.
  - Response: GAP with timeout=0.
- Asynchronous reset mid-grant:
  - Stimulus: rst_n pulsed low between edges while grant=0100.
  - Response: grant=0000, data_valid=0 and sel=00 immediately.
  - After release, last=3, so req=1111 yields grant=0001 first.
